alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU
//   control decoder and operates on two WIDTH-bit operands.
//   Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit
//   per cycle, to save area.
//   A valid/ready handshake on each side lets the core stall around multi-cycle shifts.
//   The zero flag feeds branch resolution.
// PARAMETERS
//   WIDTH   32  operand/result width; must be a power of 2, >= 8
//   SHW     5   shift-amount width = log2(WIDTH); shamt = op_b[SHW-1:0]
// PORTS
//   clk        in   1      rising-edge clock, single clock domain
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operation request valid
//   in_ready   out  1      unit can accept a request (high only in IDLE)
//   alu_ctrl   in   4      operation code (table below)
//   op_a       in   WIDTH  operand A
//   op_b       in   WIDTH  operand B / shift amount source
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  operation result
//   zero       out  1      result == 0
//   bad_op     out  1      captured code was not in the table
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, result=0,
//     zero=0, bad_op=0, shift counter=0. Reset mid-shift abandons the op; no
//     result is produced.
//   Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR, 0111 SLT (signed,
//     result 1/0, zero-extended), 0101 SLL, 0011 SRL, 1101 SRA. Any other code:
//     result=0, bad_op=1, treated as a 1-cycle op.
//   ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
//   Handshake: the request is accepted on a rising edge with in_valid&&in_ready.
//     alu_ctrl, op_a and shamt are captured at acceptance; inputs are don't-care
//     afterwards.
//   FSM:
//     IDLE  - accept; non-shift -> DONE with result computed (latency 1 cycle:
//             out_valid high the cycle after acceptance);
//             shift with shamt!=0 -> SHIFT (acc=op_a, cnt=shamt);
//             shift with shamt==0 -> DONE, result=op_a.
//     SHIFT - each cycle acc shifts by 1 (SLL: 0 in at LSB; SRL: 0 in at MSB;
//             SRA: sign bit replicated), cnt-=1; when cnt reaches 1 the final
//             shift is applied and the FSM -> DONE.
//             Shift latency = shamt+1 cycles from acceptance to out_valid.
//     DONE  - out_valid=1; result/zero/bad_op stable; on out_ready -> IDLE
//             (out_valid falls the next cycle).
//   in_ready is low in SHIFT and DONE; no back-to-back overlap. Minimum issue
//     interval is 2 cycles.
//   zero and bad_op are registered with result and are valid only while
//     out_valid=1.
//   shamt uses only op_b[SHW-1:0]; upper bits are ignored (RV32 semantics).
// TESTING
//   1. Reset mid-shift: accept SLL shamt=20, assert rst_n low at cycle 5
//      -> out_valid=0, in_ready=1 right away; next ADD completes normally.
//   2. ADD 0xFFFFFFFF+1 -> result=0, zero=1, out_valid 1 cycle after accept;
//      SUB 5-7 -> 0xFFFFFFFE, zero=0.
//   3. SLT signed: a=0x80000000, b=1 -> result=1; AND 0xF0F0_F0F0 & 0x0FF0_0FF0
//      -> 0x00F0_00F0.
//   4. Shifts, a=0x80000010: SRA shamt=4 -> 0xF8000001 after 5 cycles;
//      SRL shamt=4 -> 0x08000001; SLL shamt=31 -> 0; shamt=0 -> 0x80000010 after
//      1 cycle; op_b=0x25 uses shamt 5.
//   5. Backpressure: hold out_ready=0 for 10 cycles -> result/out_valid stable,
//      in_ready=0, and a new in_valid is ignored.
//   6. Illegal code 1111 -> result=0, bad_op=1, zero=1, latency 1; the next legal
//      op clears bad_op.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative one-bit-per-cycle shifts,
// valid/ready handshake on both sides and a registered zero flag for branch resolution.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             bad_op
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0011;
  localparam logic [3:0] OP_SRA = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_acc, w_next_acc;
  logic [SHW-1:0]   r_cnt, w_next_cnt;
  logic [3:0]       r_ctrl, w_next_ctrl;
  logic             r_zero, w_next_zero;
  logic             r_bad, w_next_bad;

  logic [SHW-1:0]   w_shamt;
  logic             w_lt;
  logic [WIDTH-1:0] w_alu;
  logic             w_is_shift;
  logic             w_illegal;
  logic [WIDTH-1:0] w_shifted;

  assign w_shamt = op_b[SHW-1:0];
  assign w_lt    = $signed(op_a) < $signed(op_b);

  always_comb begin
    w_alu      = '0;
    w_is_shift = 1'b0;
    w_illegal  = 1'b0;
    case (alu_ctrl)
      OP_AND: w_alu = op_a & op_b;
      OP_OR:  w_alu = op_a | op_b;
      OP_ADD: w_alu = op_a + op_b;
      OP_SUB: w_alu = op_a - op_b;
      OP_XOR: w_alu = op_a ^ op_b;
      OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_lt};
      OP_SLL, OP_SRL, OP_SRA: begin
        w_alu      = op_a;
        w_is_shift = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // One-bit step of the shift captured at acceptance; SRA replicates the sign bit.
  always_comb begin
    case (r_ctrl)
      OP_SLL:  w_shifted = {r_acc[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shifted = {1'b0, r_acc[WIDTH-1:1]};
      default: w_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_acc   = r_acc;
    w_next_cnt   = r_cnt;
    w_next_ctrl  = r_ctrl;
    w_next_zero  = r_zero;
    w_next_bad   = r_bad;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next_ctrl = alu_ctrl;
          w_next_acc  = w_alu;
          w_next_bad  = w_illegal;
          w_next_zero = (w_alu == '0);
          if (w_is_shift && (w_shamt != '0)) begin
            w_next_cnt   = w_shamt;
            w_next_state = SHIFT;
          end else begin
            w_next_state = DONE;
          end
        end
      end
      SHIFT: begin
        w_next_acc = w_shifted;
        w_next_cnt = r_cnt - {{(SHW-1){1'b0}}, 1'b1};
        if (r_cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
          w_next_zero  = (w_shifted == '0);
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ctrl  <= '0;
      r_zero  <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_acc   <= w_next_acc;
      r_cnt   <= w_next_cnt;
      r_ctrl  <= w_next_ctrl;
      r_zero  <= w_next_zero;
      r_bad   <= w_next_bad;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_acc;
  assign zero      = r_zero;
  assign bad_op    = r_bad;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed results and latencies.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        bad_op;

  int checks;
  int passes;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .bad_op    (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Issue one request, wait (bounded) for out_valid, capture outputs, then consume the result.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output logic z, output logic bad, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = ctrl;
    op_a     = a;
    op_b     = b;
    lat      = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctrl = 4'hx;
    op_a     = 32'hx;
    op_b     = 32'hx;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    z   = zero;
    bad = bad_op;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input logic expZero, input logic expBad, input int expLat);
    logic [31:0] res;
    logic        z, bad;
    int          lat;
    applyStimulus(ctrl, a, b, res, z, bad, lat);
    checkOutput({tag, " result"}, res, expRes);
    checkOutput({tag, " zero"}, {31'd0, z}, {31'd0, expZero});
    checkOutput({tag, " bad_op"}, {31'd0, bad}, {31'd0, expBad});
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic        z, bad;
    int          lat;
    checks    = 0;
    passes    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'h0;
    op_a      = 32'h0;
    op_b      = 32'h0;
    #12;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero", {31'd0, zero}, 32'd0);
    checkOutput("reset bad_op", {31'd0, bad_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during a long shift abandons it
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b0101;
    op_a     = 32'h8000_0010;
    op_b     = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("midshift in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midshift rst out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midshift rst in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midshift rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      checkOutput("abandoned no result", {31'd0, out_valid}, 32'd0);
    end

    runOp("ADD wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1);
    runOp("SUB", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    runOp("SLT neg<pos", 4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1);
    runOp("SLT pos<neg", 4'b0111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1);
    runOp("AND", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1);
    runOp("OR", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1);
    runOp("XOR", 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b0, 1);
    runOp("SRA 4", 4'b1101, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0, 5);
    runOp("SRL 4", 4'b0011, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 1'b0, 5);
    runOp("SLL 31", 4'b0101, 32'h8000_0010, 32'd31, 32'h0000_0000, 1'b1, 1'b0, 32);
    runOp("SLL 0", 4'b0101, 32'h8000_0010, 32'd0, 32'h8000_0010, 1'b0, 1'b0, 1);
    runOp("SLL opb 0x25", 4'b0101, 32'h8000_0010, 32'h0000_0025, 32'h0000_0200, 1'b0, 1'b0, 6);
    runOp("SRA 1", 4'b1101, 32'h4000_0003, 32'd1, 32'h2000_0001, 1'b0, 1'b0, 2);

    // Backpressure: result held, in_ready low, and an extra request ignored
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b0010;
    op_a     = 32'd100;
    op_b     = 32'd23;
    @(posedge clk);
    #1;
    alu_ctrl = 4'b0110;
    op_a     = 32'd1;
    op_b     = 32'd1;
    repeat (10) begin
      @(posedge clk);
      #1;
      checkOutput("bp out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp result", result, 32'd123);
      checkOutput("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp released", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp ignored request", {31'd0, out_valid}, 32'd0);
    checkOutput("bp idle in_ready", {31'd0, in_ready}, 32'd1);

    runOp("illegal 1111", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b1, 1);
    runOp("legal after illegal", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    applyStimulus(4'b1000, 32'h1, 32'h1, res, z, bad, lat);
    checkOutput("illegal 1000 bad_op", {31'd0, bad}, 32'd1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
